trng_harvester: RTL and testbench
=================================

// Module: trng_harvester
// PURPOSE
//  Parametrised TRNG harvester: samples external raw entropy, optionally debiases it,
//  runs a repetition-count health test, packs bits into WIDTH-bit words and buffers
//  them in a DEPTH-word FIFO. Consumers use a level request/ready handshake.
//  Sits between the ring-oscillator entropy source and the crypto cores (key/nonce gen).
// PARAMETERS
//  WIDTH      32  output word width in bits (>=2)
//  DEPTH      4   FIFO depth in words (power of 2, >=2)
//  SAMPLE_DIV 1   entropy sample strobe every SAMPLE_DIV clocks (>=1)
//  REP_LIMIT  16  consecutive identical raw samples that trip the health test (>=2)
// PORTS
//  clk            in   1                 system clock
//  rst_n          in   1                 async active-low reset
//  raw_entropy_in in   1                 asynchronous raw entropy bit
//  enable         in   1                 1 = sampling runs; 0 = sampling paused
//  trng_request   in   1                 level request for one word
//  health_clr     in   1                 1-cycle pulse: clear health_fail, resume
//  random_number  out  WIDTH             delivered word, valid while ready=1
//  ready          out  1                 word delivered for current request
//  fifo_level     out  $clog2(DEPTH)+1   words held in FIFO
//  health_fail    out  1                 sticky health-test failure
// BEHAVIOUR
//  - Reset: random_number=0, ready=0, fifo_level=0, health_fail=0; sync flops,
//    shift reg, bit/rep/div counters, FIFO pointers, FSM all cleared. Mid-op reset
//    discards partial word and FIFO contents immediately.
//  - raw_entropy_in passes a 2-flop synchroniser (reset 0). Strobe fires on the
//    cycle the divider counter reaches SAMPLE_DIV-1 while enable=1 && !health_fail
//    && !stall; divider holds when not enabled.
//  - Harvested bit b shifts in: sr <= {sr[WIDTH-2:0], b}; first bit ends as MSB.
//  - When WIDTH-th bit harvested: word pushed same edge if FIFO not full, bit count
//    -> 0. If FIFO full: word held in sr, stall=1 (no strobes) until a pop frees a
//    slot; push then occurs, no bits lost or duplicated.
//  - Push and pop same cycle when full or empty-but-pushing: both legal, level
//    updated by net change.
//  - Health: rep counter compares each strobed raw sample (pre-debias) with the
//    previous; equal -> count+1, else count=1. Count reaching REP_LIMIT sets
//    health_fail next edge and same edge clears sr, bit count, FIFO (level -> 0).
//    While health_fail=1: no sampling, no pushes, no new deliveries. health_clr
//    clears health_fail and rep count; sampling resumes next strobe.
//  - Output FSM: IDLE -> (request && level>0 && !health_fail) DONE, pop, load
//    random_number, ready=1 on next edge; IDLE -> (request, no word) WAIT;
//    WAIT -> DONE as soon as a word is available; DONE holds ready=1 while
//    request=1; any state -> IDLE with ready=0 the edge after request drops.
//    Latency with FIFO non-empty: ready 1 cycle after request rises. Exactly one
//    word per request assertion. random_number keeps last value after ready drops.
//  - health_fail while in DONE: ready stays until request drops (word already valid).
// CONFIGURATION
//  TRNG_VN_DEBIAS_EN defined: von Neumann corrector on strobed bits; pair (first,
//    second): 01 -> harvest 0, 10 -> harvest 1, 00/11 -> discarded. Pairs are
//    non-overlapping; pair phase clears on reset, health trip, health_clr.
//  Undefined: every strobed bit is harvested directly. Health test identical in both.
// TESTING (WIDTH=8, DEPTH=2, SAMPLE_DIV=1, REP_LIMIT=16 unless stated)
//  1 Drive 1,0,1,1,0,0,1,0 one per cycle, request after level=1 -> ready 1 cycle
//    later, random_number=8'hB2, level 0; drop request -> ready=0 next edge.
//  2 Request with empty FIFO -> ready held 0 (WAIT); first word pushed -> ready=1 on
//    next edge with that word; holding request yields no second pop.
//  3 Fill with 8'hA5,8'h3C, keep sampling -> level=2, stall, third word held;
//    request -> 8'hA5, level stays 2 after held 3rd word pushes; order A5,3C,3rd.
//  4 REP_LIMIT=4, drive constant 1 -> health_fail=1 after 4th sample, level=0,
//    request -> no ready; health_clr pulse -> health_fail=0, harvesting resumes.
//  5 TRNG_VN_DEBIAS_EN: pairs 01,10,11,00,10 ... -> harvested 0,1,1; 8 valid pairs
//    10,01,10,10,01,01,10,01 -> word 8'hB2.
//  6 Assert rst_n=0 mid-word with level=1 and ready=1 -> all outputs 0 immediately.

Source files
------------

// File: rtl/trng_harvester.sv
// trng_harvester: samples raw entropy, health-tests it, packs WIDTH-bit words into a DEPTH-word FIFO served by request/ready.
// Define TRNG_VN_DEBIAS_EN to insert a von Neumann corrector between the sampler and the word packer.
module trng_harvester #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 4,
  parameter int SAMPLE_DIV = 1,
  parameter int REP_LIMIT  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     raw_entropy_in,
  input  logic                     enable,
  input  logic                     trng_request,
  input  logic                     health_clr,
  output logic [WIDTH-1:0]         random_number,
  output logic                     ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     health_fail
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(WIDTH);
  localparam int DW = $clog2(SAMPLE_DIV) + 1;
  localparam int RW = $clog2(REP_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic             sync1, sync2, prev, hold;
  logic             run, strobe, trip, harvest, hbit, word_done, full, avail, can, push, pop;
  logic [DW-1:0]    div;
  logic [RW-1:0]    rep, rep_nxt;
  logic [WIDTH-1:0] sr, word;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;

  assign run       = enable && !health_fail && !hold;
  assign strobe    = run && (div == DW'(SAMPLE_DIV - 1));
  assign rep_nxt   = (rep != '0 && sync2 == prev) ? rep + RW'(1) : RW'(1);
  assign trip      = strobe && (rep_nxt == RW'(REP_LIMIT));
  assign word      = {sr[WIDTH-2:0], hbit};
  assign word_done = harvest && (bit_cnt == BW'(WIDTH - 1));
  assign full      = fifo_level == LW'(DEPTH);
  assign avail     = (fifo_level != '0) && !health_fail;
  assign can       = !full || pop;
  assign push      = (word_done || hold) && can;
  assign ready     = state == DONE;

`ifdef TRNG_VN_DEBIAS_EN
  logic vn_ph, vn_first;
  assign harvest = strobe && !trip && vn_ph && (vn_first != sync2);
  assign hbit    = vn_first;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vn_ph    <= 1'b0;
      vn_first <= 1'b0;
    end else if (trip || health_clr) begin
      vn_ph <= 1'b0;
    end else if (strobe) begin
      vn_ph <= !vn_ph;
      if (!vn_ph) vn_first <= sync2;
    end
  end
`else
  assign harvest = strobe && !trip;
  assign hbit    = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      div         <= '0;
      rep         <= '0;
      prev        <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      sync1 <= raw_entropy_in;
      sync2 <= sync1;
      if (run) div <= (div == DW'(SAMPLE_DIV - 1)) ? '0 : div + DW'(1);
      if (health_clr) rep <= '0;
      else if (strobe) rep <= rep_nxt;
      if (strobe) prev <= sync2;
      health_fail <= trip ? 1'b1 : health_clr ? 1'b0 : health_fail;
    end
  end

  // A completed word that cannot enter the FIFO stays in sr and stalls sampling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      bit_cnt <= '0;
      hold    <= 1'b0;
    end else if (trip) begin
      sr      <= '0;
      bit_cnt <= '0;
      hold    <= 1'b0;
    end else if (hold) begin
      hold <= !can;
    end else if (harvest) begin
      sr      <= word;
      bit_cnt <= word_done ? '0 : bit_cnt + BW'(1);
      hold    <= word_done && !can;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= hold ? sr : word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
    end else if (trip) begin
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    if (!trng_request) state_nxt = IDLE;
    else if (state != DONE) begin
      pop       = avail;
      state_nxt = avail ? DONE : WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      random_number <= '0;
    end else begin
      state <= state_nxt;
      if (pop) random_number <= mem[rp];
    end
  end
endmodule

// File: tb/tb_trng_harvester.sv
// tb_trng_harvester: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_trng_harvester;
  localparam int W = 8, D = 2, SD = 1, RL = 16;

  logic clk = 0, rst_n = 0, raw = 0, en = 0, req = 0, clr = 0;
  logic [W-1:0] rn;
  logic         rdy, hf;
  logic [1:0]   lvl;

  trng_harvester #(.WIDTH(W), .DEPTH(D), .SAMPLE_DIV(SD), .REP_LIMIT(RL)) dut (
    .clk(clk), .rst_n(rst_n), .raw_entropy_in(raw), .enable(en), .trng_request(req),
    .health_clr(clr), .random_number(rn), .ready(rdy), .fifo_level(lvl), .health_fail(hf)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  bit         syncq[$];
  bit         part[$];
  bit         stream[$];
  logic [W-1:0] fifo[$];
  int         m_div, m_rep;
  bit         m_prev, m_hf, m_held, m_rdy, vn_ph, vn_first;
  logic [W-1:0] m_hw, m_rn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    syncq = '{0, 0};
    part.delete(); fifo.delete(); stream.delete();
    m_div = 0; m_rep = 0; m_prev = 0; m_hf = 0; m_held = 0; m_rdy = 0;
    vn_ph = 0; vn_first = 0; m_hw = 0; m_rn = 0;
  endtask

  task automatic take_bit(input bit b, input bit can);
    logic [W-1:0] w;
    part.push_back(b);
    if (part.size() == W) begin
      w = 0;
      foreach (part[i]) w = (w << 1) | W'(part[i]);
      part.delete();
      if (can) fifo.push_back(w);
      else begin m_held = 1; m_hw = w; end
    end
  endtask

  // One clock of the reference: sample as the spec describes, serve one word per request.
  task automatic model_step();
    bit b, avail, pop, can, run, strobe;
    b = syncq.pop_front();
    syncq.push_back(raw);
    avail  = fifo.size() > 0 && !m_hf;
    pop    = req && !m_rdy && avail;
    can    = fifo.size() < D || pop;
    run    = en && !m_hf && !m_held;
    strobe = run && m_div == SD - 1;
    if (run) m_div = (m_div + 1) % SD;
    m_rdy = req && (m_rdy || avail);
    if (pop) m_rn = fifo.pop_front();
    if (m_held && can) begin fifo.push_back(m_hw); m_held = 0; end
    if (clr) begin m_hf = 0; m_rep = 0; vn_ph = 0; end
    if (strobe) begin
      m_rep  = (m_rep > 0 && b == m_prev) ? m_rep + 1 : 1;
      m_prev = b;
      if (m_rep == RL) begin
        m_hf = 1; part.delete(); fifo.delete(); vn_ph = 0;
      end else begin
`ifdef TRNG_VN_DEBIAS_EN
        if (!vn_ph) begin vn_first = b; vn_ph = 1; end
        else begin vn_ph = 0; if (vn_first != b) take_bit(vn_first, can); end
`else
        take_bit(b, can);
`endif
      end
    end
  endtask

  task automatic cyc(input bit e, input bit b, input bit r, input bit c);
    en = e; raw = b; req = r; clr = c;
    @(posedge clk);
    model_step();
    #1;
    check("ready", rdy, m_rdy);
    check("random_number", rn, m_rn);
    check("fifo_level", lvl, fifo.size());
    check("health_fail", hf, m_hf);
  endtask

  task automatic add_byte(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) begin
`ifdef TRNG_VN_DEBIAS_EN
      stream.push_back(w[i]); stream.push_back(!w[i]);
`else
      stream.push_back(w[i]);
`endif
    end
  endtask

  // Enable lags the data by the synchroniser depth so every strobe lands on a stream bit.
  task automatic run_stream(input bit r);
    int n;
    n = stream.size();
    for (int i = 0; i < n + 2; i++) cyc(i >= 2, i < n ? stream[i] : 1'b0, r, 0);
    stream.delete();
  endtask

  task automatic do_reset();
    rst_n = 0; en = 0; req = 0; clr = 0; raw = 0;
    #3;
    check("rst_ready", rdy, 0);
    check("rst_random_number", rn, 0);
    check("rst_fifo_level", lvl, 0);
    check("rst_health_fail", hf, 0);
    @(negedge clk);
    rst_n = 1;
    mreset();
  endtask

  initial begin
    bit stuck;
    mreset();
    #12;
    do_reset();

    add_byte(8'hB2);
    run_stream(0);
    check("t1_level", lvl, 1);
    cyc(0, 0, 1, 0);
    check("t1_ready", rdy, 1);
    check("t1_word", rn, 8'hB2);
    check("t1_level_after", lvl, 0);
    cyc(0, 0, 0, 0);
    check("t1_ready_drop", rdy, 0);

    do_reset();
    repeat (3) cyc(0, 0, 1, 0);
    check("t2_wait", rdy, 0);
    add_byte(8'h5A);
    run_stream(1);
    check("t2_not_yet", rdy, 0);
    cyc(0, 0, 1, 0);
    check("t2_ready", rdy, 1);
    check("t2_word", rn, 8'h5A);
    add_byte(8'h3C);
    run_stream(1);
    check("t2_no_second_pop", lvl, 1);
    cyc(0, 0, 0, 0);

    do_reset();
    add_byte(8'hA5); add_byte(8'h3C); add_byte(8'h69);
    run_stream(0);
    check("t3_full", lvl, 2);
    cyc(0, 0, 1, 0);
    check("t3_first", rn, 8'hA5);
    check("t3_level_held", lvl, 2);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    check("t3_second", rn, 8'h3C);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    check("t3_third", rn, 8'h69);
    cyc(0, 0, 0, 0);

    do_reset();
    repeat (RL) stream.push_back(1'b1);
    run_stream(0);
    check("t4_fail", hf, 1);
    check("t4_level", lvl, 0);
    repeat (3) cyc(1, 1, 1, 0);
    check("t4_no_ready", rdy, 0);
    cyc(0, 0, 0, 1);
    check("t4_cleared", hf, 0);
    add_byte(8'hB2);
    run_stream(0);
    cyc(0, 0, 1, 0);
    check("t4_resume", rn, 8'hB2);
    cyc(0, 0, 0, 0);

`ifdef TRNG_VN_DEBIAS_EN
    do_reset();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] v;
      v = 8'hB2;
      stream.push_back(1'b1); stream.push_back(1'b1);
      stream.push_back(v[i]); stream.push_back(!v[i]);
      stream.push_back(1'b0); stream.push_back(1'b0);
    end
    run_stream(0);
    cyc(0, 0, 1, 0);
    check("t5_vn_word", rn, 8'hB2);
    cyc(0, 0, 0, 0);
`endif

    do_reset();
    add_byte(8'h11);
    run_stream(0);
    cyc(0, 0, 1, 0);
    add_byte(8'h22);
    run_stream(1);
    check("t6_ready_pre", rdy, 1);
    check("t6_level_pre", lvl, 1);
    do_reset();

    stuck = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) stuck = !stuck;
      if ($urandom_range(0, 5) == 0) req = !req;
      cyc($urandom_range(0, 9) != 0, stuck ? 1'b1 : 1'($urandom), req,
          m_hf && $urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
